// File: rtl/t64_rgb888_to_cag444_k8.sv
`default_nettype none
// ============================================================================
// Module   : t64_rgb888_to_cag444_k8
// Purpose  : RGB888 -> CAG444 encoder. One shared 8x9 signed multiplier runs
//            nine multiply-accumulate steps (Y, Cb, Cr x R, G, B), then each
//            channel is scaled, offset, clamped and reduced to its top nibble.
// Revision : 1.0 - initial release
// ============================================================================
module t64_rgb888_to_cag444_k8 #(
  parameter bit ID    = 1'b0,
  parameter bit ROUND = 1'b1
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_rgb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_cag,
  output logic        out_sat
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_mac  = 2'd1;
  localparam logic [1:0] c_st_out  = 2'd2;

  localparam logic signed [19:0] c_rnd = ROUND ? 20'sd64 : 20'sd0;

  logic [1:0]         r_state;
  logic [3:0]         r_step;
  logic [23:0]        r_rgb;
  logic signed [19:0] r_acc;
  logic               r_sat;
  logic [3:0]         r_y_nib;
  logic [3:0]         r_cb_nib;

  logic signed [7:0]  w_coef;
  logic [7:0]         w_opnd;
  logic signed [16:0] w_prod;
  logic signed [19:0] w_sum;
  logic signed [19:0] w_v;
  logic signed [19:0] w_t;
  logic [7:0]         w_chan8;
  logic               w_clip;
  logic               w_last;

  // The instance tag has no functional role.
  logic w_unused_id;
  assign w_unused_id = ID;

  // Coefficient and colour operand for the current MAC step (Y, Cb, Cr rows; R, G, B columns).
  always_comb begin
    w_coef = 8'sd0;
    w_opnd = r_rgb[7:0];
    case (r_step)
      4'd0: w_coef = 8'sd38;
      4'd1: w_coef = 8'sd75;
      4'd2: w_coef = 8'sd15;
      4'd3: w_coef = -8'sd22;
      4'd4: w_coef = -8'sd42;
      4'd5: w_coef = 8'sd64;
      4'd6: w_coef = 8'sd64;
      4'd7: w_coef = -8'sd54;
      4'd8: w_coef = -8'sd10;
      default: w_coef = 8'sd0;
    endcase
    case (r_step)
      4'd0, 4'd3, 4'd6: w_opnd = r_rgb[23:16];
      4'd1, 4'd4, 4'd7: w_opnd = r_rgb[15:8];
      default:          w_opnd = r_rgb[7:0];
    endcase
  end

  // Multiply, accumulate and finish the channel completed on steps 2, 5 and 8.
  always_comb begin
    w_prod  = w_coef * $signed({1'b0, w_opnd});
    w_sum   = r_acc + {{3{w_prod[16]}}, w_prod};
    w_v     = (w_sum + c_rnd) >>> 7;
    // Luma has no offset; both chroma channels are centred on 128.
    w_t     = (r_step == 4'd2) ? w_v : (w_v + 20'sd128);
    w_clip  = 1'b0;
    w_chan8 = w_t[7:0];
    if (w_t[19]) begin
      w_chan8 = 8'd0;
      w_clip  = 1'b1;
    end else if (w_t > 20'sd255) begin
      w_chan8 = 8'd255;
      w_clip  = 1'b1;
    end
    w_last = (r_step == 4'd2) || (r_step == 4'd5) || (r_step == 4'd8);
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state   <= c_st_idle;
      r_step    <= 4'd0;
      r_rgb     <= 24'd0;
      r_acc     <= 20'sd0;
      r_sat     <= 1'b0;
      r_y_nib   <= 4'd0;
      r_cb_nib  <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_cag   <= 12'h000;
      out_sat   <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_rgb    <= in_rgb;
            r_step   <= 4'd0;
            r_acc    <= 20'sd0;
            r_sat    <= 1'b0;
            in_ready <= 1'b0;
            r_state  <= c_st_mac;
          end
        end
        c_st_mac: begin
          r_step <= r_step + 4'd1;
          if (w_last) begin
            r_acc <= 20'sd0;
            r_sat <= r_sat | w_clip;
            if (r_step == 4'd2) r_y_nib  <= w_chan8[7:4];
            if (r_step == 4'd5) r_cb_nib <= w_chan8[7:4];
            if (r_step == 4'd8) begin
              out_cag   <= {r_cb_nib, w_chan8[7:4], r_y_nib};
              out_sat   <= r_sat | w_clip;
              out_valid <= 1'b1;
              r_state   <= c_st_out;
            end
          end else begin
            r_acc <= w_sum;
          end
        end
        c_st_out: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= c_st_idle;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= c_st_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_t64_rgb888_to_cag444_k8.sv
`default_nettype none
// ============================================================================
// Module   : tb_t64_rgb888_to_cag444_k8
// Purpose  : Scoreboard bench for the RGB888 -> CAG444 encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t64_rgb888_to_cag444_k8;

  localparam bit ROUND_P = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_rgb = 24'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_cag;
  logic        out_sat;

  int n_vec = 0;
  int n_err = 0;
  logic [12:0] q[$];

  t64_rgb888_to_cag444_k8 #(.ID(1'b0), .ROUND(ROUND_P)) dut (
    .ap_clk   (clk),
    .ap_rst   (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rgb   (in_rgb),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_cag  (out_cag),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int clip(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Reference encoder: returns {sat, cag}.
  function automatic logic [12:0] model(input logic [23:0] p);
    int r, g, b, rnd, y, cb, cr, yc, cbc, crc;
    logic [7:0] y8, cb8, cr8;
    logic s;
    r   = int'(p[23:16]);
    g   = int'(p[15:8]);
    b   = int'(p[7:0]);
    rnd = ROUND_P ? 64 : 0;
    y   = (38 * r + 75 * g + 15 * b + rnd) >>> 7;
    cb  = ((-22 * r - 42 * g + 64 * b + rnd) >>> 7) + 128;
    cr  = ((64 * r - 54 * g - 10 * b + rnd) >>> 7) + 128;
    yc  = clip(y);
    cbc = clip(cb);
    crc = clip(cr);
    s   = (yc != y) || (cbc != cb) || (crc != cr);
    y8  = yc[7:0];
    cb8 = cbc[7:0];
    cr8 = crc[7:0];
    return {s, cb8[7:4], cr8[7:4], y8[7:4]};
  endfunction

  // Offer a pixel, wait for acceptance, return edges from accept to out_valid.
  task automatic send(input logic [23:0] rgb, output int lat);
    int t;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_rgb   = rgb;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("accept_timeout", 32'd0, 32'd1);
    q.push_back(model(rgb));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard: compare each result at the cycle its handshake completes.
  always @(negedge clk) begin
    logic [12:0] e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {20'd0, out_cag}, 32'hDEAD);
      end else begin
        e = q.pop_front();
        chk("cag", {20'd0, out_cag}, {20'd0, e[11:0]});
        chk("sat", {31'd0, out_sat}, {31'd0, e[12]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [12:0] held;
    logic [23:0] vecs [6];
    vecs[0] = 24'h000000;
    vecs[1] = 24'hFFFFFF;
    vecs[2] = 24'hFF0000;
    vecs[3] = 24'h0000FF;
    vecs[4] = 24'($urandom);
    vecs[5] = 24'($urandom);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_cag", {20'd0, out_cag}, 32'h000);
    chk("rst_out_sat", {31'd0, out_sat}, 32'd0);

    // Known vectors plus a couple of random pixels, each with a latency check.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i], lat);
      chk("latency", lat, 32'd9);
    end
    drain();

    // Backpressure with a second pixel offered while busy.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(24'h123456, lat);
    chk("bp_latency", lat, 32'd9);
    held = model(24'h123456);
    in_valid = 1'b1;
    in_rgb   = 24'h9A3C7E;
    q.push_back(model(24'h9A3C7E));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_cag", {20'd0, out_cag}, {20'd0, held[11:0]});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("second_accepted", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("second_latency", lat, 32'd9);
    drain();

    // Asynchronous reset during MAC step 4 aborts the pixel.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_rgb   = 24'hABCDEF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_cag", {20'd0, out_cag}, 32'h000);
    chk("abort_sat", {31'd0, out_sat}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("abort_no_out", {31'd0, out_valid}, 32'd0);
    end
    send(24'h00FF00, lat);
    chk("after_abort_latency", lat, 32'd9);
    drain();

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
